// File: rtl/cpu15_pkg.sv
// Shared cpu15 data-memory constants and IO port state type; also used by ram_dc.
package cpu15_pkg;

  localparam int         DATA_W    = 16;
  localparam int         RAM_DEPTH = 8;
  localparam logic [7:0] IO64_ADDR = 8'h40;
  localparam logic [7:0] IO65_ADDR = 8'h41;

  typedef enum logic {
    IO_IDLE = 1'b0,
    IO_FULL = 1'b1
  } io_state_t;

  // Full 8-bit compare, so no upper-address aliasing onto the RAM words.
  function automatic logic is_ram_addr(input logic [7:0] addr);
    return addr < 8'(RAM_DEPTH);
  endfunction

endpackage

// File: rtl/io64_port.sv
// IO64 output register with valid/ack handshake; store-to-valid 1 cycle, ack-to-idle 1 cycle.
// Stalls a store combinationally while unconsumed data is held and the device is not acking.
module io64_port
  import cpu15_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              ack,
  output logic [DATA_W-1:0] io_data,
  output logic              io_vld,
  output logic              stall
);

  io_state_t         state_q, state_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic              hit;

  assign hit = wr_en && (wr_addr == IO64_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IO_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_nxt;
      data_q  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    data_nxt  = data_q;
    stall     = 1'b0;
    case (state_q)
      IO_IDLE: begin
        if (hit) begin
          data_nxt  = wr_data;
          state_nxt = IO_FULL;
        end
      end
      IO_FULL: begin
        if (hit) begin
          // An ack in the same cycle frees the slot, so the new value replaces it.
          if (ack) data_nxt = wr_data;
          else     stall    = 1'b1;
        end else if (ack) begin
          state_nxt = IO_IDLE;
        end
      end
      default: state_nxt = IO_IDLE;
    endcase
  end

  assign io_data = data_q;
  assign io_vld  = (state_q == IO_FULL);

endmodule

// File: rtl/ram_wb.sv
// cpu15 data-memory write-back: 8 RAM words (1-cycle store) plus IO64 output port.
// IO64 port present only with RAM_WB_IO64_EN; otherwise IO64 outputs tie to 0 and never stall.
module ram_wb
  import cpu15_pkg::*;
(
  input  logic              CLK_WB,
  input  logic              RST,
  input  logic [7:0]        RAM_AD_IN,
  input  logic [DATA_W-1:0] RAM_IN,
  input  logic              RAM_WEN,
  input  logic              IO64_ACK,
  output logic [DATA_W-1:0] RAM_0,
  output logic [DATA_W-1:0] RAM_1,
  output logic [DATA_W-1:0] RAM_2,
  output logic [DATA_W-1:0] RAM_3,
  output logic [DATA_W-1:0] RAM_4,
  output logic [DATA_W-1:0] RAM_5,
  output logic [DATA_W-1:0] RAM_6,
  output logic [DATA_W-1:0] RAM_7,
  output logic [DATA_W-1:0] IO64_OUT,
  output logic              IO64_VALID,
  output logic              WB_STALL
);

  localparam int AW = $clog2(RAM_DEPTH);

  logic [DATA_W-1:0] ram_q [RAM_DEPTH];

  always_ff @(posedge CLK_WB or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= '0;
    end else if (RAM_WEN && is_ram_addr(RAM_AD_IN)) begin
      ram_q[RAM_AD_IN[AW-1:0]] <= RAM_IN;
    end
  end

  assign RAM_0 = ram_q[0];
  assign RAM_1 = ram_q[1];
  assign RAM_2 = ram_q[2];
  assign RAM_3 = ram_q[3];
  assign RAM_4 = ram_q[4];
  assign RAM_5 = ram_q[5];
  assign RAM_6 = ram_q[6];
  assign RAM_7 = ram_q[7];

`ifdef RAM_WB_IO64_EN
  io64_port u_io64_port (
    .clk     (CLK_WB),
    .rst     (RST),
    .wr_addr (RAM_AD_IN),
    .wr_data (RAM_IN),
    .wr_en   (RAM_WEN),
    .ack     (IO64_ACK),
    .io_data (IO64_OUT),
    .io_vld  (IO64_VALID),
    .stall   (WB_STALL)
  );
`else
  logic unused_io64_ack;
  assign unused_io64_ack = IO64_ACK;
  assign IO64_OUT        = '0;
  assign IO64_VALID      = 1'b0;
  assign WB_STALL        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_wb.sv
// Directed bench for ram_wb; expectations follow the IO64 build option in use.
module tb_ram_wb;
  import cpu15_pkg::*;

`ifdef RAM_WB_IO64_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ad  = 8'h00;
  logic [15:0] din = 16'h0000;
  logic        wen = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7, io_out;
  logic        io_vld, stall;
  logic [15:0] ram_o [8];
  logic [15:0] exp_ram [8];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          idx;   // RAM word expected to change, -1 for none
  } vec_t;
  vec_t vecs [11];

  ram_wb dut (
    .CLK_WB(clk), .RST(rst), .RAM_AD_IN(ad), .RAM_IN(din), .RAM_WEN(wen), .IO64_ACK(ack),
    .RAM_0(r0), .RAM_1(r1), .RAM_2(r2), .RAM_3(r3),
    .RAM_4(r4), .RAM_5(r5), .RAM_6(r6), .RAM_7(r7),
    .IO64_OUT(io_out), .IO64_VALID(io_vld), .WB_STALL(stall)
  );

  always #5 clk = ~clk;

  always_comb ram_o = '{r0, r1, r2, r3, r4, r5, r6, r7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_ram%0d", tag, i), ram_o[i], exp_ram[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{8'h00, 16'h6535, 0};
    vecs[1]  = '{8'h01, 16'h7628, 1};
    vecs[2]  = '{8'h02, 16'h7e6e, 2};
    vecs[3]  = '{8'h03, 16'habcd, 3};
    vecs[4]  = '{8'h04, 16'h64a6, 4};
    vecs[5]  = '{8'h05, 16'h0000, 5};
    vecs[6]  = '{8'h06, 16'h34b1, 6};
    vecs[7]  = '{8'h07, 16'h808d, 7};
    vecs[8]  = '{8'h41, 16'hdead, -1};
    vecs[9]  = '{8'h08, 16'hbeef, -1};
    vecs[10] = '{8'hc2, 16'hface, -1};
    for (int i = 0; i < 8; i++) exp_ram[i] = 16'h0000;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #1;
    check_ram("rst");
    chk("rst_io_out", io_out, 16'h0000);
    chk("rst_io_vld", io_vld, 1'b0);
    chk("rst_stall", stall, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // RAM fill, one store per cycle, then unmapped addresses
    for (int v = 0; v < 11; v++) begin
      ad = vecs[v].addr; din = vecs[v].data; wen = 1'b1;
      #1 chk($sformatf("fill%0d_stall", v), stall, 1'b0);
      step();
      if (vecs[v].idx >= 0) exp_ram[vecs[v].idx] = vecs[v].data;
      check_ram($sformatf("fill%0d", v));
    end
    wen = 1'b0;
    chk("fill_io_vld", io_vld, 1'b0);

    // IO64 store then ack
    ad = 8'h40; din = 16'h324f; wen = 1'b1; ack = 1'b0;
    #1 chk("io_wr_stall", stall, 1'b0);
    step(); wen = 1'b0;
    chk("io_wr_vld", io_vld, IO_EN);
    chk("io_wr_out", io_out, IO_EN ? 16'h324f : 16'h0000);
    check_ram("io_wr");
    ack = 1'b1;
    #1 chk("io_ack_stall", stall, 1'b0);
    step(); ack = 1'b0;
    chk("io_ack_vld", io_vld, 1'b0);
    chk("io_ack_out", io_out, IO_EN ? 16'h324f : 16'h0000);
    ack = 1'b1; step(); ack = 1'b0;
    chk("idle_ack_vld", io_vld, 1'b0);

    // Fill the port, then stall a second store until the device acks
    ad = 8'h40; din = 16'habcd; wen = 1'b1;
    step();
    din = 16'h1111;
    #1 chk("stall_on", stall, IO_EN);
    step();
    chk("stall_hold_out", io_out, IO_EN ? 16'habcd : 16'h0000);
    chk("stall_hold_vld", io_vld, IO_EN);
    chk("stall_still", stall, IO_EN);
    ack = 1'b1;
    #1 chk("stall_ack_stall", stall, 1'b0);
    step();
    chk("stall_ack_out", io_out, IO_EN ? 16'h1111 : 16'h0000);
    chk("stall_ack_vld", io_vld, IO_EN);

    // Back-to-back stores with the device acking every cycle
    for (int k = 0; k < 4; k++) begin
      din = 16'h2000 + 16'(k);
      #1 chk($sformatf("b2b%0d_stall", k), stall, 1'b0);
      step();
      chk($sformatf("b2b%0d_out", k), io_out, IO_EN ? 16'h2000 + 32'(k) : 32'h0);
      chk($sformatf("b2b%0d_vld", k), io_vld, IO_EN);
    end
    wen = 1'b0; step(); ack = 1'b0;
    chk("b2b_drain_vld", io_vld, 1'b0);

    // RAM and IO65 stores never stall while the port is full
    ad = 8'h40; din = 16'h5a5a; wen = 1'b1; step();
    ad = 8'h03; din = 16'hbeef;
    #1 chk("full_ram_stall", stall, 1'b0);
    step(); exp_ram[3] = 16'hbeef;
    check_ram("full_ram");
    ad = 8'h41; din = 16'h7777;
    #1 chk("full_io65_stall", stall, 1'b0);
    step(); wen = 1'b0;
    check_ram("full_io65");
    chk("full_io65_vld", io_vld, IO_EN);
    chk("full_io65_out", io_out, IO_EN ? 16'h5a5a : 16'h0000);

    // Reset mid-handshake: port holding 16'habcd, reset between edges
    ad = 8'h40; din = 16'habcd; wen = 1'b1; ack = 1'b1; step();
    chk("pre_rst_out", io_out, IO_EN ? 16'habcd : 16'h0000);
    ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) exp_ram[i] = 16'h0000;
    check_ram("mid_rst");
    chk("mid_rst_vld", io_vld, 1'b0);
    chk("mid_rst_out", io_out, 16'h0000);
    chk("mid_rst_stall", stall, 1'b0);
    wen = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    ad = 8'h40; din = 16'h4321; wen = 1'b1; ack = 1'b0;
    #1 chk("post_rst_stall", stall, 1'b0);
    step(); wen = 1'b0;
    chk("post_rst_vld", io_vld, IO_EN);
    chk("post_rst_out", io_out, IO_EN ? 16'h4321 : 16'h0000);
    check_ram("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
